// File: rtl/mmm_ctrl_if.sv
// Handshake bundle between mmm_ctrl and its neighbours: input_mems, mac_pipe and fifo_out.
// The controller takes the master side; the environment, or a bench, takes the slave side.
interface mmm_ctrl_if #(
   parameter int M     = 7,
   parameter int N     = 9,
   parameter int MAXK  = 8,
   parameter int DEPTH = 9
);
   localparam int K_BITS = $clog2(MAXK + 1);
   localparam int A_W    = $clog2(M * MAXK);
   localparam int B_W    = $clog2(MAXK * N);
   localparam int C_W    = $clog2(DEPTH + 1);

   logic              matrices_loaded;
   logic [K_BITS-1:0] K;
   logic              compute_finished;
   logic [A_W-1:0]    A_read_addr;
   logic [B_W-1:0]    B_read_addr;
   logic              valid_input;
   logic              clear_acc;
   logic              fifo_wr_en;
   logic [C_W-1:0]    fifo_capacity;

   modport master (
      input  matrices_loaded, K, fifo_capacity,
      output compute_finished, A_read_addr, B_read_addr, valid_input, clear_acc, fifo_wr_en
   );

   modport slave (
      output matrices_loaded, K, fifo_capacity,
      input  compute_finished, A_read_addr, B_read_addr, valid_input, clear_acc, fifo_wr_en
   );
endinterface

// File: rtl/mmm_ctrl.sv
// Matrix-multiply sequencer: walks C[m][n] in row-major order, issues one term per cycle and
// aligns the MAC controls and FIFO writes to the read latency, gated by fifo_out credit.
module mmm_ctrl #(
   parameter int M       = 7,
   parameter int N       = 9,
   parameter int MAXK    = 8,
   parameter int MAC_LAT = 2,
   parameter int DEPTH   = 9
) (
   input  logic       clk,
   input  logic       reset,
   mmm_ctrl_if.master bus
);
   localparam int K_BITS = $clog2(MAXK + 1);
   localparam int A_W    = $clog2(M * MAXK);
   localparam int B_W    = $clog2(MAXK * N);
   localparam int C_W    = $clog2(DEPTH + 1);
   localparam int M_W    = (M > 1) ? $clog2(M) : 1;
   localparam int N_W    = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t            state, state_nxt;
   logic [M_W-1:0]    m, m_nxt;
   logic [N_W-1:0]    n, n_nxt;
   logic [K_BITS-1:0] k, k_nxt;
   logic [K_BITS-1:0] k_lat, k_lat_nxt;
   logic [C_W-1:0]    outstanding, outstanding_nxt;
   logic [A_W-1:0]    a_addr, a_addr_nxt;
   logic [B_W-1:0]    b_addr, b_addr_nxt;
   // Alignment pipe: bit 0 is the data cycle, bit MAC_LAT is the write cycle.
   logic [MAC_LAT:0]  pipe_valid, pipe_first, pipe_last;
   logic              issue, start, last_k, wr_en, drained;

   assign last_k  = (k == k_lat - K_BITS'(1));
   assign wr_en   = pipe_valid[MAC_LAT] & pipe_last[MAC_LAT];
   assign drained = (pipe_valid[MAC_LAT-1:0] == '0) &&
                    ((outstanding == '0) || ((outstanding == C_W'(1)) && wr_en));

   // NOTE: every variable gets a default before the case, so no path leaves one unassigned (no latches).
   always_comb begin
      state_nxt = state;
      k_lat_nxt = k_lat;
      m_nxt     = m;
      n_nxt     = n;
      k_nxt     = k;
      issue     = 1'b0;
      start     = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.matrices_loaded) begin
               k_lat_nxt = bus.K;
               m_nxt     = '0;
               n_nxt     = '0;
               k_nxt     = '0;
               state_nxt = (bus.K == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            // Only a new dot product needs a free slot; its remaining terms never stall.
            issue = (k != '0) || (bus.fifo_capacity > outstanding);
            start = issue && (k == '0);
            if (issue) begin
               if (last_k) begin
                  k_nxt = '0;
                  if (n == N_W'(N - 1)) begin
                     n_nxt = '0;
                     if (m == M_W'(M - 1)) begin
                        m_nxt     = '0;
                        state_nxt = DRAIN;
                     end else begin
                        m_nxt = m + M_W'(1);
                     end
                  end else begin
                     n_nxt = n + N_W'(1);
                  end
               end else begin
                  k_nxt = k + K_BITS'(1);
               end
            end
         end
         DRAIN: if (drained) state_nxt = DONE;
         DONE:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      outstanding_nxt = outstanding;
      if (start && !wr_en)      outstanding_nxt = outstanding + C_W'(1);
      else if (!start && wr_en) outstanding_nxt = outstanding - C_W'(1);
   end

   // Addresses are registered from the next counter values so they are valid in the issue cycle.
   assign a_addr_nxt = A_W'(m_nxt) * A_W'(k_lat_nxt) + A_W'(k_nxt);
   assign b_addr_nxt = B_W'(k_nxt) * B_W'(N) + B_W'(n_nxt);

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         k_lat       <= '0;
         m           <= '0;
         n           <= '0;
         k           <= '0;
         outstanding <= '0;
         a_addr      <= '0;
         b_addr      <= '0;
         pipe_valid  <= '0;
         pipe_first  <= '0;
         pipe_last   <= '0;
      end else begin
         state       <= state_nxt;
         k_lat       <= k_lat_nxt;
         m           <= m_nxt;
         n           <= n_nxt;
         k           <= k_nxt;
         outstanding <= outstanding_nxt;
         a_addr      <= a_addr_nxt;
         b_addr      <= b_addr_nxt;
         pipe_valid  <= {pipe_valid[MAC_LAT-1:0], issue};
         pipe_first  <= {pipe_first[MAC_LAT-1:0], issue && (k == '0)};
         pipe_last   <= {pipe_last[MAC_LAT-1:0], issue && last_k};
      end
   end

   assign bus.A_read_addr      = a_addr;
   assign bus.B_read_addr      = b_addr;
   assign bus.valid_input      = pipe_valid[0];
   assign bus.clear_acc        = pipe_valid[0] & pipe_first[0];
   assign bus.fifo_wr_en       = wr_en;
   assign bus.compute_finished = (state == DONE);
endmodule

// File: tb/tb_mmm_ctrl.sv
// Bench for mmm_ctrl: models the memories, MAC and fifo_out around the controller and checks
// addresses, write timing and results against a row-major matrix-product reference.
module tb_mmm_ctrl;
   localparam int M       = 7;
   localparam int N       = 9;
   localparam int MAXK    = 8;
   localparam int MAC_LAT = 2;
   localparam int DEPTH   = 9;
   localparam int C_W     = $clog2(DEPTH + 1);

   typedef struct {
      int cyc;
      int a;
      int b;
      int clr;
   } term_t;

   logic clk = 1'b0;
   logic reset = 1'b0;

   mmm_ctrl_if #(.M(M), .N(N), .MAXK(MAXK), .DEPTH(DEPTH)) bus ();

   mmm_ctrl #(.M(M), .N(N), .MAXK(MAXK), .MAC_LAT(MAC_LAT), .DEPTH(DEPTH)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int t0 = 0;
   int mem_a[M*MAXK];
   int mem_b[MAXK*N];
   int acc = 0;
   int acc_hist[8];
   int a_prev = 0;
   int b_prev = 0;
   bit model_mode = 1'b0;
   int cap_force = DEPTH;
   bit rd_en = 1'b0;
   bit rd_once = 1'b0;
   int fifo_q[$];
   term_t terms[$];
   term_t exp_terms[$];
   int wr_cycles[$];
   int results[$];
   int exp_c[$];
   int fin_cycles[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock of environment: drive credit, then consume this cycle's DUT outputs.
   task automatic tick();
      int v;
      @(negedge clk);
      cyc++;
      if (model_mode) bus.fifo_capacity = C_W'(DEPTH - fifo_q.size());
      else            bus.fifo_capacity = C_W'(cap_force);
      if (reset) begin
         if ((rd_en || rd_once) && fifo_q.size() > 0) begin
            v = fifo_q.pop_front();
            rd_once = 1'b0;
            if (v >= 0) results.push_back(v);
         end
         if (bus.valid_input === 1'b1) begin
            v = mem_a[a_prev % (M*MAXK)] * mem_b[b_prev % (MAXK*N)];
            acc = (bus.clear_acc === 1'b1) ? v : acc + v;
            terms.push_back('{cyc: cyc - 1, a: a_prev, b: b_prev, clr: int'(bus.clear_acc)});
         end
         acc_hist[cyc % 8] = acc;
         if (bus.fifo_wr_en === 1'b1) begin
            wr_cycles.push_back(cyc);
            v = acc_hist[(cyc - MAC_LAT) % 8];
            if (model_mode) begin
               check("fifo_not_full_on_write", fifo_q.size() < DEPTH, 1);
               fifo_q.push_back(v);
            end else begin
               results.push_back(v);
            end
         end
         if (bus.compute_finished === 1'b1) begin
            fin_cycles.push_back(cyc);
            bus.matrices_loaded = 1'b0;
         end
      end
      a_prev = int'(bus.A_read_addr);
      b_prev = int'(bus.B_read_addr);
   endtask

   task automatic clear_logs();
      terms.delete();
      wr_cycles.delete();
      results.delete();
      fin_cycles.delete();
      acc = 0;
   endtask

   task automatic build_ref(input int kd);
      int sum;
      exp_terms.delete();
      exp_c.delete();
      for (int mi = 0; mi < M; mi++) begin
         for (int ni = 0; ni < N; ni++) begin
            sum = 0;
            for (int ki = 0; ki < kd; ki++) begin
               exp_terms.push_back('{cyc: 0, a: mi*kd + ki, b: ki*N + ni, clr: (ki == 0) ? 1 : 0});
               sum += mem_a[mi*kd + ki] * mem_b[ki*N + ni];
            end
            if (kd > 0) exp_c.push_back(sum);
         end
      end
   endtask

   task automatic start(input int kd);
      for (int i = 0; i < M*MAXK; i++) mem_a[i] = int'($urandom_range(0, 15));
      for (int i = 0; i < MAXK*N; i++) mem_b[i] = int'($urandom_range(0, 15));
      build_ref(kd);
      clear_logs();
      bus.K = kd[3:0];
      bus.matrices_loaded = 1'b1;
      t0 = cyc;
      tick();
   endtask

   task automatic wait_done(input int budget);
      int waited = 0;
      while (fin_cycles.size() == 0 && waited < budget) begin
         tick();
         waited++;
      end
      check("finished_within_budget", fin_cycles.size() > 0, 1);
      bus.matrices_loaded = 1'b0;
      repeat (12) tick();
   endtask

   task automatic check_run(input int kd, input bit timing);
      int nt;
      int nw;
      check("term_count", terms.size(), M*N*kd);
      nt = (terms.size() < exp_terms.size()) ? terms.size() : exp_terms.size();
      for (int i = 0; i < nt; i++) begin
         check($sformatf("A_read_addr[%0d]", i), terms[i].a, exp_terms[i].a);
         check($sformatf("B_read_addr[%0d]", i), terms[i].b, exp_terms[i].b);
         check($sformatf("clear_acc[%0d]", i), terms[i].clr, exp_terms[i].clr);
         if (timing) check($sformatf("issue_cycle[%0d]", i), terms[i].cyc - t0, i + 1);
      end
      check("write_count", wr_cycles.size(), (kd == 0) ? 0 : M*N);
      nw = wr_cycles.size();
      for (int j = 0; j < nw; j++) begin
         if (timing && (j*kd + kd - 1) < terms.size())
            check($sformatf("write_latency[%0d]", j), wr_cycles[j],
                  terms[j*kd + kd - 1].cyc + 1 + MAC_LAT);
      end
      check("result_count", results.size(), exp_c.size());
      for (int j = 0; j < results.size() && j < exp_c.size(); j++)
         check($sformatf("C[%0d][%0d]", j / N, j % N), results[j], exp_c[j]);
      check("finish_pulses", fin_cycles.size(), 1);
      if (timing && fin_cycles.size() > 0 && nw > 0) begin
         check("last_write_cycle", wr_cycles[nw-1] - t0, M*N*kd + 1 + MAC_LAT);
         check("finish_cycle", fin_cycles[0] - t0, M*N*kd + 2 + MAC_LAT);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_compute_finished"}, bus.compute_finished, 0);
      check({tag, "_A_read_addr"}, bus.A_read_addr, 0);
      check({tag, "_B_read_addr"}, bus.B_read_addr, 0);
      check({tag, "_valid_input"}, bus.valid_input, 0);
      check({tag, "_clear_acc"}, bus.clear_acc, 0);
      check({tag, "_fifo_wr_en"}, bus.fifo_wr_en, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.matrices_loaded = 1'b0;
      bus.K = '0;
      bus.fifo_capacity = '0;
      repeat (2) tick();
      check_zero("reset");
      reset = 1'b1;
      tick();

      // Full run, K=3, credit held at DEPTH.
      start(3);
      wait_done(1000);
      check_run(3, 1'b1);

      // K=1: every term clears the accumulator.
      start(1);
      wait_done(500);
      check_run(1, 1'b1);

      // Start against a full FIFO; free a single slot in cycle 20.
      model_mode = 1'b1;
      rd_en = 1'b0;
      fifo_q.delete();
      repeat (DEPTH) fifo_q.push_back(-1);
      start(2);
      while (cyc < t0 + 18) tick();
      check("no_issue_while_full", terms.size(), 0);
      rd_once = 1'b1;
      tick();
      repeat (30) tick();
      check("single_dot_terms", terms.size(), 2);
      check("single_dot_writes", wr_cycles.size(), 1);
      if (terms.size() > 0) check("single_dot_issue_cycle", terms[0].cyc - t0, 20);
      rd_en = 1'b1;
      wait_done(2000);
      check_run(2, 1'b0);

      // FIFO never read, K=4: exactly DEPTH writes, then issue stops until reads resume.
      fifo_q.delete();
      rd_en = 1'b0;
      start(4);
      repeat (80) tick();
      check("writes_until_full", wr_cycles.size(), DEPTH);
      check("terms_until_full", terms.size(), DEPTH*4);
      repeat (20) tick();
      check("issue_halted_when_full", terms.size(), DEPTH*4);
      rd_en = 1'b1;
      wait_done(2000);
      check_run(4, 1'b0);

      // K=0 goes straight to DONE.
      model_mode = 1'b0;
      start(0);
      wait_done(50);
      if (fin_cycles.size() > 0) check("k0_finish_cycle", fin_cycles[0] - t0, 1);
      check_run(0, 1'b0);

      // Asynchronous reset mid-run, then a clean full run.
      start(3);
      repeat (50) tick();
      #2;
      reset = 1'b0;
      bus.matrices_loaded = 1'b0;
      #1;
      check_zero("reset_mid_run");
      tick();
      reset = 1'b1;
      clear_logs();
      repeat (10) tick();
      check("post_reset_terms", terms.size(), 0);
      check("post_reset_writes", wr_cycles.size(), 0);
      check("post_reset_finish", fin_cycles.size(), 0);
      start(3);
      wait_done(1000);
      check_run(3, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
